time_set_entry: RTL and testbench

- Button-driven time-setting controller; produces the packed 20-bit BCD time word that the clock core loads and the LED display stage decodes.
- Writer side of the time word interface: debounces user buttons, steps through hours/minutes/seconds fields, increments digits with BCD wrap, and issues a one-cycle overwrite strobe on commit.
- Sits between the board push-buttons and digital_clock (time_in/time_ow).

---
 rtl/time_set_entry.sv | 209 ++++++++++++++++++++
 tb/tb_time_set_entry.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/time_set_entry.sv
// Button-driven BCD time-setting controller feeding the clock core load port.
// Define TIME_SET_DEC_EN to add btn_dec for decrementing the selected field.
module time_set_entry #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] EDIT_TIMEOUT    = 32'd500000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
`ifdef TIME_SET_DEC_EN
    input  logic        btn_dec,
`endif
    input  logic [19:0] time_cur,
    output logic [19:0] time_in,
    output logic        time_ow,
    output logic        edit_active,
    output logic [1:0]  edit_field
);

    typedef enum logic [2:0] {
        IDLE, EDIT_HRS, EDIT_MIN, EDIT_SEC, COMMIT
    } state_t;

`ifdef TIME_SET_DEC_EN
    localparam int NB = 3;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_dec, btn_inc, btn_mode};
`else
    localparam int NB = 2;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_inc, btn_mode};
`endif

    logic [NB-1:0] btn_p;

    // Level counts as pressed only after DEBOUNCE_CYCLES consecutive high samples.
    for (genvar i = 0; i < NB; i++) begin : g_db
        logic        s1_q, s2_q, prev_q, lvl;
        logic [15:0] cnt_q;
        assign lvl = s2_q && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
        assign btn_p[i] = lvl & ~prev_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                prev_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                s1_q   <= btn_raw[i];
                s2_q   <= s1_q;
                prev_q <= lvl;
                if (!s2_q)
                    cnt_q <= '0;
                else if (cnt_q != DEBOUNCE_CYCLES - 16'd1)
                    cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    function automatic logic [19:0] sanitize(input logic [19:0] t);
        logic [19:0] r;
        r = t;
        if (t[17:14] > 4'd9 || t[19:18] > 2'd2 ||
            (t[19:18] == 2'd2 && t[17:14] > 4'd3))
            r[19:14] = '0;
        if (t[13:11] > 3'd5 || t[10:7] > 4'd9)
            r[13:7] = '0;
        if (t[6:4] > 3'd5 || t[3:0] > 4'd9)
            r[6:0] = '0;
        return r;
    endfunction

    function automatic logic [5:0] hrs_inc(input logic [5:0] h);
        if (h[5:4] == 2'd2 && h[3:0] >= 4'd3) return 6'd0;
        if (h[3:0] >= 4'd9) return {h[5:4] + 2'd1, 4'd0};
        return {h[5:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] ms_inc(input logic [6:0] m);
        if (m[3:0] >= 4'd9)
            return {(m[6:4] >= 3'd5) ? 3'd0 : m[6:4] + 3'd1, 4'd0};
        return {m[6:4], m[3:0] + 4'd1};
    endfunction

`ifdef TIME_SET_DEC_EN
    function automatic logic [5:0] hrs_dec(input logic [5:0] h);
        if (h == 6'd0) return {2'd2, 4'd3};
        if (h[3:0] == 4'd0) return {h[5:4] - 2'd1, 4'd9};
        return {h[5:4], h[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] ms_dec(input logic [6:0] m);
        if (m[3:0] == 4'd0)
            return {(m[6:4] == 3'd0) ? 3'd5 : m[6:4] - 3'd1, 4'd9};
        return {m[6:4], m[3:0] - 4'd1};
    endfunction
`endif

    state_t      state_q, state_d;
    logic [19:0] edit_q, edit_d, last_q, last_d, step_v;
    logic [31:0] to_q, to_d;
    logic        ow_d, active_d;
    logic [1:0]  field_d;
    logic        mode_p, inc_go, in_edit, to_hit;

    assign mode_p = btn_p[0];
`ifdef TIME_SET_DEC_EN
    logic dec_go;
    assign inc_go = btn_p[1] & ~mode_p & ~btn_p[2];
    assign dec_go = btn_p[2] & ~mode_p & ~btn_p[1];
`else
    assign inc_go = btn_p[1] & ~mode_p;
`endif

    assign in_edit = (state_q == EDIT_HRS) || (state_q == EDIT_MIN) ||
                     (state_q == EDIT_SEC);
    assign to_hit  = in_edit && (to_q == EDIT_TIMEOUT - 32'd1);
    assign time_in = edit_q;

    always_comb begin
        step_v = edit_q;
        if (inc_go) begin
            unique case (1'b1)
                state_q == EDIT_HRS: step_v[19:14] = hrs_inc(edit_q[19:14]);
                state_q == EDIT_MIN: step_v[13:7]  = ms_inc(edit_q[13:7]);
                state_q == EDIT_SEC: step_v[6:0]   = ms_inc(edit_q[6:0]);
                default: ;
            endcase
        end
`ifdef TIME_SET_DEC_EN
        if (dec_go) begin
            unique case (1'b1)
                state_q == EDIT_HRS: step_v[19:14] = hrs_dec(edit_q[19:14]);
                state_q == EDIT_MIN: step_v[13:7]  = ms_dec(edit_q[13:7]);
                state_q == EDIT_SEC: step_v[6:0]   = ms_dec(edit_q[6:0]);
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            edit_q      <= '0;
            last_q      <= '0;
            to_q        <= '0;
            time_ow     <= 1'b0;
            edit_active <= 1'b0;
            edit_field  <= 2'b00;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            last_q      <= last_d;
            to_q        <= to_d;
            time_ow     <= ow_d;
            edit_active <= active_d;
            edit_field  <= field_d;
        end
    end

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (mode_p) begin
                    state_d = EDIT_HRS;
                    edit_d  = sanitize(time_cur);
                end
            end
            EDIT_HRS, EDIT_MIN, EDIT_SEC: begin
                if (mode_p) begin
                    state_d = (state_q == EDIT_HRS) ? EDIT_MIN :
                              (state_q == EDIT_MIN) ? EDIT_SEC : COMMIT;
                end else if (to_hit) begin
                    state_d = IDLE;
                    edit_d  = last_q;
                end else begin
                    edit_d = step_v;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                last_d  = edit_q;
            end
            default: state_d = IDLE;
        endcase
        if ((|btn_p) || (state_d != state_q) || !in_edit)
            to_d = '0;
        else
            to_d = to_q + 32'd1;
    end

    always_comb begin
        ow_d     = (state_d == COMMIT);
        active_d = 1'b0;
        field_d  = 2'b00;
        unique case (state_d)
            EDIT_HRS: begin active_d = 1'b1; field_d = 2'b01; end
            EDIT_MIN: begin active_d = 1'b1; field_d = 2'b10; end
            EDIT_SEC: begin active_d = 1'b1; field_d = 2'b11; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_time_set_entry.sv
// Directed bench for time_set_entry with short debounce and timeout.
// Decrement vectors run only when TIME_SET_DEC_EN is defined.
module tb_time_set_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
`ifdef TIME_SET_DEC_EN
    logic        btn_dec = 1'b0;
`endif
    logic [19:0] time_cur = '0;
    logic [19:0] time_in;
    logic        time_ow;
    logic        edit_active;
    logic [1:0]  edit_field;

    int n_cmp = 0;
    int n_err = 0;
    int ow_cnt = 0;
    logic [19:0] ow_word = '0;

    time_set_entry #(
        .DEBOUNCE_CYCLES(16'd4),
        .EDIT_TIMEOUT(32'd20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
`ifdef TIME_SET_DEC_EN
        .btn_dec(btn_dec),
`endif
        .time_cur(time_cur),
        .time_in(time_in),
        .time_ow(time_ow),
        .edit_active(edit_active),
        .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (time_ow) begin
            ow_cnt  = ow_cnt + 1;
            ow_word = time_in;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    function automatic logic [19:0] bcd(input int h, input int m, input int s);
        logic [1:0] ht;
        logic [2:0] mt, st;
        logic [3:0] hu, mu, su;
        ht = 2'(h / 10); hu = 4'(h % 10);
        mt = 3'(m / 10); mu = 4'(m % 10);
        st = 3'(s / 10); su = 4'(s % 10);
        return {ht, hu, mt, mu, st, su};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic m, input logic i, input logic d,
                         input int n);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
`ifdef TIME_SET_DEC_EN
        btn_dec  = d;
`endif
        repeat (n) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
`ifdef TIME_SET_DEC_EN
        btn_dec  = 1'b0;
`else
        if (d) $display("note: dec press ignored in this build");
`endif
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_time_in", 32'(time_in), 32'h0);
        check("rst_ow", 32'(time_ow), 32'h0);
        check("rst_active", 32'(edit_active), 32'h0);
        check("rst_field", 32'(edit_field), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        press(1'b1, 1'b0, 1'b0, 3);
        repeat (4) @(negedge clk);
        check("glitch_active", 32'(edit_active), 32'h0);
        check("glitch_field", 32'(edit_field), 32'h0);

        time_cur = bcd(12, 34, 56);
        press(1'b1, 1'b0, 1'b0, 6);
        check("enter_field", 32'(edit_field), 32'h1);
        repeat (3) @(negedge clk);
        check("enter_hold", 32'(edit_field), 32'h1);
        check("capture", 32'(time_in), 32'(bcd(12, 34, 56)));
        for (int k = 0; k < 11; k++) press(1'b0, 1'b1, 1'b0, 6);
        check("hrs_12p11", 32'(time_in), 32'(bcd(23, 34, 56)));
        ow_cnt = 0;
        press(1'b1, 1'b0, 1'b0, 6);
        check("field_min", 32'(edit_field), 32'h2);
        press(1'b1, 1'b0, 1'b0, 6);
        check("field_sec", 32'(edit_field), 32'h3);
        press(1'b1, 1'b1, 1'b0, 6);
        check("commit_ow_cnt", 32'(ow_cnt), 32'h1);
        check("commit_word", 32'(ow_word), 32'(bcd(23, 34, 56)));
        check("commit_active", 32'(edit_active), 32'h0);
        check("commit_field", 32'(edit_field), 32'h0);
        check("commit_hold", 32'(time_in), 32'(bcd(23, 34, 56)));

        ow_cnt = 0;
        time_cur = bcd(5, 9, 30);
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 6);
        check("min_09_inc", 32'(time_in), 32'(bcd(5, 10, 30)));
        repeat (10) @(negedge clk);
        check("to_not_yet", 32'(edit_field), 32'h2);
        repeat (10) @(negedge clk);
        check("to_active", 32'(edit_active), 32'h0);
        check("to_field", 32'(edit_field), 32'h0);
        check("to_restore", 32'(time_in), 32'(bcd(23, 34, 56)));
        check("to_no_ow", 32'(ow_cnt), 32'h0);

        time_cur = bcd(23, 59, 59);
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 6);
        check("hrs_wrap", 32'(time_in), 32'(bcd(0, 59, 59)));
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 6);
        check("min_wrap", 32'(time_in), 32'(bcd(0, 0, 59)));
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 6);
        check("sec_wrap", 32'(time_in), 32'(bcd(0, 0, 0)));
        press(1'b1, 1'b0, 1'b0, 6);
        check("wrap_ow_cnt", 32'(ow_cnt), 32'h1);

        time_cur = {2'b11, 4'b0101, 7'b1111001, 3'd4, 4'd2};
        press(1'b1, 1'b0, 1'b0, 6);
        check("sanitize", 32'(time_in), 32'(bcd(0, 0, 42)));

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_time", 32'(time_in), 32'h0);
        check("mid_rst_ow", 32'(time_ow), 32'h0);
        check("mid_rst_active", 32'(edit_active), 32'h0);
        check("mid_rst_field", 32'(edit_field), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef TIME_SET_DEC_EN
        time_cur = bcd(0, 40, 0);
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b0, 1'b1, 6);
        check("dec_hrs", 32'(time_in), 32'(bcd(23, 40, 0)));
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b0, 1'b1, 6);
        check("dec_min", 32'(time_in), 32'(bcd(23, 39, 0)));
        press(1'b0, 1'b1, 1'b1, 6);
        check("inc_dec_drop", 32'(time_in), 32'(bcd(23, 39, 0)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
